// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, req/ack data-memory port, MEM-stage forwarding and branch
// redirect, MEM/WB register. Optional ack timeout enabled by defining MEM_ACK_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_aluresult,
  input  logic [WIDTH-1:0] ex_storedata,
  input  logic [4:0]       ex_rd,
  input  logic [5:0]       ex_ctrl,
  input  logic             ex_zero,
  input  logic [WIDTH-1:0] ex_branchaddr,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic [WIDTH-1:0] fwd_aluout,
  output logic [4:0]       fwd_rd,
  output logic             fwd_regwrite,
  output logic             pcsrc,
  output logic [WIDTH-1:0] branch_target,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_regwrite,
  output logic             mem_fault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // EX/MEM pipeline register
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_alu;
  logic [WIDTH-1:0] r_m_sd;
  logic [4:0]       r_m_rd;
  logic [5:0]       r_m_ctrl;
  logic             r_m_zero;
  logic [WIDTH-1:0] r_m_br;
  logic [1:0]       r_state;

  // MEM/WB pipeline register
  logic             r_wb_valid;
  logic [WIDTH-1:0] r_wb_data;
  logic [4:0]       r_wb_rd;
  logic             r_wb_regwrite;

  logic       w_in_wait;
  logic       w_ack;
  logic       w_timeout;
  logic       w_complete;
  logic       w_stall;
  logic       w_capture;
  logic [1:0] w_next_state;
  logic       w_unused;

  assign w_in_wait  = (r_state == ST_WAIT);
  // Ack only counts while a transaction is outstanding; stray acks are ignored.
  assign w_ack      = w_in_wait & dmem_ack;
  assign w_complete = (r_state == ST_EXEC) | w_ack | w_timeout;
  assign w_stall    = w_in_wait & ~w_ack & ~w_timeout;
  assign w_capture  = ~w_stall;

  always_comb begin
    w_next_state = r_state;
    if (w_capture) begin
      if (!ex_valid) begin
        w_next_state = ST_IDLE;
      end else if (ex_ctrl[1] | ex_ctrl[2]) begin
        w_next_state = ST_WAIT;
      end else begin
        w_next_state = ST_EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_m_valid <= 1'b0;
      r_m_alu   <= '0;
      r_m_sd    <= '0;
      r_m_rd    <= '0;
      r_m_ctrl  <= '0;
      r_m_zero  <= 1'b0;
      r_m_br    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_m_valid <= ex_valid;
        r_m_alu   <= ex_aluresult;
        r_m_sd    <= ex_storedata;
        r_m_rd    <= ex_rd;
        r_m_ctrl  <= ex_ctrl;
        r_m_zero  <= ex_zero;
        r_m_br    <= ex_branchaddr;
      end
    end
  end

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_fault;

  // Retire on the TIMEOUT-th unacknowledged WAIT cycle.
  assign w_timeout = w_in_wait & ~dmem_ack & (r_to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign mem_fault = r_fault;
`else
  assign w_timeout = 1'b0;
  assign mem_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_valid <= w_complete;
      if (w_complete) begin
        r_wb_rd <= r_m_rd;
        if (w_timeout) begin
          r_wb_regwrite <= 1'b0;
          r_wb_data     <= '0;
        end else begin
          r_wb_regwrite <= r_m_ctrl[3];
          r_wb_data     <= r_m_ctrl[4] ? dmem_rdata : r_m_alu;
        end
      end
    end
  end

  assign mem_stall     = w_stall;
  assign dmem_req      = w_in_wait;
  assign dmem_we       = r_m_ctrl[2];
  assign dmem_addr     = r_m_alu;
  assign dmem_wdata    = r_m_sd;

  // Loads are never forwarded from MEM, and x0 is never a forwarding source.
  assign fwd_aluout    = r_m_alu;
  assign fwd_rd        = r_m_rd;
  assign fwd_regwrite  = r_m_valid & r_m_ctrl[3] & ~r_m_ctrl[4] & (r_m_rd != 5'd0);

  assign pcsrc         = r_m_valid & r_m_ctrl[0] & r_m_zero;
  assign branch_target = r_m_br;

  assign wb_valid      = r_wb_valid;
  assign wb_data       = r_wb_data;
  assign wb_rd         = r_wb_rd;
  assign wb_regwrite   = r_wb_regwrite;

  assign w_unused = ^{r_m_ctrl[5], (TIMEOUT != 0)};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instruction streams, checked every cycle
// against a transaction-level model of the stage and a bench-side memory responder.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] br;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic        zero;
    logic [7:0]  lat;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_aluresult, ex_storedata, ex_branchaddr;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_ctrl;
  logic        ex_zero;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] fwd_aluout;
  logic [4:0]  fwd_rd;
  logic        fwd_regwrite, pcsrc;
  logic [31:0] branch_target;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, mem_fault;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_aluresult(ex_aluresult),
    .ex_storedata(ex_storedata), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_zero(ex_zero),
    .ex_branchaddr(ex_branchaddr), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .fwd_aluout(fwd_aluout), .fwd_rd(fwd_rd),
    .fwd_regwrite(fwd_regwrite), .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_fault(mem_fault)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model state: the instruction currently in MEM and what writeback should show next cycle.
  instr_t      pres, cur;
  logic        cur_valid = 1'b0;
  int          cur_wait = 0;
  logic        exp_wbv = 1'b0, exp_wbrw = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_wbd = '0;
  logic [4:0]  exp_wbrd = '0;
  logic        force_ack = 1'b0;
  logic        consumed;
  int          req_cnt, stall_cnt, pcsrc_cnt, wb_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic instr_t mk(input logic [5:0] ctrl, input logic [31:0] alu,
                                input logic [31:0] sd, input logic [4:0] rd, input logic zero,
                                input logic [31:0] br, input logic [31:0] rdata,
                                input logic [7:0] lat);
    instr_t i;
    i.ctrl = ctrl; i.alu = alu; i.sd = sd; i.rd = rd; i.zero = zero;
    i.br = br; i.rdata = rdata; i.lat = lat;
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    int k;
    k = $urandom_range(0, 4);
    i.alu = $urandom; i.sd = $urandom; i.br = $urandom; i.rdata = $urandom;
    i.rd = 5'($urandom); i.zero = 1'($urandom); i.lat = 8'($urandom_range(0, 5));
    case (k)
      0:       i.ctrl = {1'($urandom), 1'b0, 1'($urandom), 3'b000};
      1:       i.ctrl = 6'b011010;
      2:       i.ctrl = {2'b00, 1'($urandom), 3'b100};
      3:       i.ctrl = 6'b000110;
      default: i.ctrl = 6'b000001;
    endcase
    return i;
  endfunction

  task automatic present(input logic v, input instr_t i);
    pres = i;
    ex_valid = v; ex_aluresult = i.alu; ex_storedata = i.sd; ex_rd = i.rd;
    ex_ctrl = i.ctrl; ex_zero = i.zero; ex_branchaddr = i.br;
  endtask

  // One clock: check outputs at negedge, respond on the memory port, model the next edge.
  task automatic cycle();
    logic memop, ack_now, to, done;
    @(negedge clk);
    memop = cur_valid && (cur.ctrl[1] || cur.ctrl[2]);
    chk("wb_valid", wb_valid, exp_wbv);
    chk("wb_data", wb_data, exp_wbd);
    chk("wb_rd", wb_rd, exp_wbrd);
    chk("wb_regwrite", wb_regwrite, exp_wbrw);
    chk("mem_fault", mem_fault, exp_fault);
    chk("dmem_req", dmem_req, memop);
    if (memop) begin
      chk("dmem_we", dmem_we, cur.ctrl[2]);
      chk("dmem_addr", dmem_addr, cur.alu);
      if (cur.ctrl[2]) chk("dmem_wdata", dmem_wdata, cur.sd);
    end
    if (cur_valid) begin
      chk("fwd_aluout", fwd_aluout, cur.alu);
      chk("fwd_rd", fwd_rd, cur.rd);
      chk("branch_target", branch_target, cur.br);
    end
    chk("fwd_regwrite", fwd_regwrite,
        cur_valid && cur.ctrl[3] && !cur.ctrl[4] && (cur.rd != 5'd0));
    chk("pcsrc", pcsrc, cur_valid && cur.ctrl[0] && cur.zero);
    if (dmem_req === 1'b1) req_cnt++;
    if (pcsrc === 1'b1) pcsrc_cnt++;
    if (wb_valid === 1'b1) wb_cnt++;

    if (memop) ack_now = (cur_wait == int'(cur.lat));
    else ack_now = force_ack || ($urandom_range(0, 1) == 1);
    dmem_ack = ack_now;
    dmem_rdata = (memop && ack_now) ? cur.rdata : $urandom;
    to = 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
    to = memop && !ack_now && (cur_wait == 14);
`endif
    #1;
    chk("mem_stall", mem_stall, memop && !ack_now && !to);
    if (mem_stall === 1'b1) stall_cnt++;

    done = cur_valid && (!memop || ack_now || to);
    exp_wbv = done;
    if (done) begin
      exp_wbrd = cur.rd;
      if (to) begin
        exp_wbrw = 1'b0; exp_wbd = '0; exp_fault = 1'b1;
      end else begin
        exp_wbrw = cur.ctrl[3];
        exp_wbd = cur.ctrl[4] ? cur.rdata : cur.alu;
      end
    end
    if (memop && !ack_now && !to) begin
      cur_wait++;
    end else begin
      cur_valid = ex_valid; cur = pres; cur_wait = 0;
      if (ex_valid) consumed = 1'b1;
    end
    if (reset) begin
      cur_valid = 1'b0; exp_wbv = 1'b0; exp_wbd = '0; exp_wbrd = '0;
      exp_wbrw = 1'b0; exp_fault = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_t i);
    int n;
    n = 0;
    consumed = 1'b0;
    present(1'b1, i);
    while (!consumed && n < 300) begin
      cycle();
      n++;
    end
    chk("issue_accepted", consumed, 1'b1);
    present(1'b0, i);
  endtask

  task automatic idle(input int n);
    present(1'b0, pres);
    repeat (n) cycle();
  endtask

  task automatic clr();
    req_cnt = 0; stall_cnt = 0; pcsrc_cnt = 0; wb_cnt = 0;
  endtask

  initial begin
    int n_rand;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    present(1'b0, mk(6'd0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    clr();
    idle(2);
    chk("reset_no_req", req_cnt, 0);
    chk("reset_no_stall", stall_cnt, 0);

    // ALU op
    clr();
    issue(mk(6'b001000, 32'h10, 32'h0, 5'd5, 1'b0, 32'h0, 32'h0, 8'd0));
    idle(3);
    chk("alu_stall_cycles", stall_cnt, 0);
    chk("alu_wb_count", wb_cnt, 1);

    // Load, ack after 3 request cycles
    clr();
    issue(mk(6'b011010, 32'h100, 32'h0, 5'd7, 1'b0, 32'h0, 32'hDEADBEEF, 8'd2));
    idle(6);
    chk("load_req_cycles", req_cnt, 3);
    chk("load_stall_cycles", stall_cnt, 2);
    chk("load_wb_count", wb_cnt, 1);

    // Store, zero-cycle ack
    clr();
    issue(mk(6'b000100, 32'h20, 32'h55, 5'd9, 1'b0, 32'h0, 32'h0, 8'd0));
    idle(3);
    chk("store_req_cycles", req_cnt, 1);
    chk("store_stall_cycles", stall_cnt, 0);

    // Back-to-back load, add, branch
    clr();
    issue(mk(6'b011010, 32'h200, 32'h0, 5'd3, 1'b0, 32'h0, 32'h12345678, 8'd1));
    issue(mk(6'b001000, 32'h77, 32'h0, 5'd4, 1'b0, 32'h0, 32'h0, 8'd0));
    issue(mk(6'b000001, 32'h0, 32'h0, 5'd0, 1'b1, 32'h40, 32'h0, 8'd0));
    idle(4);
    chk("b2b_pcsrc_cycles", pcsrc_cnt, 1);
    chk("b2b_wb_count", wb_cnt, 3);
    chk("b2b_stall_cycles", stall_cnt, 1);

    // Reset while waiting, then a late ack
    clr();
    issue(mk(6'b011010, 32'h300, 32'h0, 5'd6, 1'b0, 32'h0, 32'hCAFEF00D, 8'd255));
    idle(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    force_ack = 1'b1;
    idle(3);
    force_ack = 1'b0;
    chk("rst_wait_wb_count", wb_cnt, 0);
    chk("rst_wait_req_cycles", req_cnt, 3);

`ifdef MEM_ACK_TIMEOUT_EN
    clr();
    issue(mk(6'b011010, 32'h400, 32'h0, 5'd8, 1'b0, 32'h0, 32'h0, 8'd255));
    idle(20);
    chk("timeout_req_cycles", req_cnt, 15);
    chk("timeout_wb_count", wb_cnt, 1);
    chk("timeout_fault_sticky", mem_fault, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(1);
`endif

    // Random streams
    clr();
    n_rand = 200;
    for (int k = 0; k < n_rand; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(rnd());
    end
    idle(12);
    chk("rand_wb_count", wb_cnt, n_rand);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
